// File: rtl/npu_pkg.sv
// npu_pkg
//   Definitions shared by the NPU datapath stages (activation, pooling).
//   DATA_W  : width of one post-activation pixel.
//   pixel_t : one pixel, always treated as an unsigned magnitude.
//   pixel_max : unsigned maximum of two pixels.
package npu_pkg;

  localparam int DATA_W = 22;

  typedef logic [DATA_W-1:0] pixel_t;

  // Unsigned full-width maximum. Post-ReLU pixels are never negative, so
  // a signed compare would misorder values that have the top bit set.
  function automatic pixel_t pixel_max(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer
//   Simple dual-port storage for the horizontal pair maxima of an even row.
//   One entry per 2-pixel column pair, so DEPTH is half the image width.
//   The read port is registered (block-RAM friendly): data requested with
//   rd_en appears on rd_data after the next rising edge and then holds
//   until the next read. There is no reset; every entry is rewritten
//   during an even row before the following odd row reads it.
//
// Ports
//   clk      : clock, rising edge
//   wr_en    : write wr_data into entry wr_addr
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : load entry rd_addr into rd_data
//   rd_addr  : read address
//   rd_data  : registered read data
module pool_line_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 22
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/max_pool_2x2.sv
// max_pool_2x2
//   Streaming 2x2, stride-2 max pooling over one IMG_W x IMG_H feature map
//   delivered in raster order. One pooled pixel is produced per
//   non-overlapping 2x2 window, also in raster order, one cycle after the
//   pixel that completes the window (odd row, odd column). No backpressure:
//   every cycle with pixel_valid high consumes a pixel; idle cycles freeze
//   all state.
//
//   Datapath per accepted pixel:
//     even col : h_prev <= pixel
//     odd col  : hmax = max(h_prev, pixel)
//                even row -> line_buf[col/2] <= hmax
//                odd row  -> result = max(line_buf[col/2], hmax)
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   pixel_valid  : pixel_in carries a pixel this cycle
//   pixel_in     : post-ReLU pixel, unsigned
//   result_valid : result_out carries a pooled pixel this cycle
//   result_out   : maximum of one 2x2 window; holds while result_valid is low
//   frame_done   : one-cycle pulse with the last pooled pixel of a frame
module max_pool_2x2
  import npu_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int DATA_W = npu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixel_valid,
  input  logic [DATA_W-1:0] pixel_in,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_out,
  output logic              frame_done
);

  localparam int COL_W  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int HALF_W = IMG_W / 2;
  localparam int ADDR_W = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  // Row-parity FSM encoding.
  localparam logic [0:0] ROW_EVEN = 1'b0;
  localparam logic [0:0] ROW_ODD  = 1'b1;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [COL_W-1:0]  col_reg,   col_next;
  logic [ROW_W-1:0]  row_reg,   row_next;
  logic [0:0]        state_reg, state_next;
  logic [DATA_W-1:0] h_prev_reg;

  // ---------------------------------------------------------------------
  // Position decode
  // ---------------------------------------------------------------------
  logic col_odd;
  logic col_last;
  logic row_last;

  assign col_odd  = col_reg[0];
  assign col_last = (col_reg == COL_W'(IMG_W - 1));
  assign row_last = (row_reg == ROW_W'(IMG_H - 1));

  // ---------------------------------------------------------------------
  // Counters: advance only on accepted pixels; col wraps into row, row
  // wraps at the end of the frame so the next pixel is (0,0).
  // ---------------------------------------------------------------------
  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (pixel_valid) begin
      if (col_last) begin
        col_next = '0;
        row_next = row_last ? '0 : (row_reg + 1'b1);
      end else begin
        col_next = col_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Row-parity FSM: flips on every row wrap, including the frame wrap
  // (IMG_H is even, so the last row is always odd and the frame restarts
  // in ROW_EVEN).
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (pixel_valid && col_last) begin
      case (state_reg)
        ROW_EVEN: state_next = ROW_ODD;
        ROW_ODD:  state_next = ROW_EVEN;
        default:  state_next = ROW_EVEN;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Horizontal pair maximum
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] hmax;

  assign hmax = (pixel_in > h_prev_reg) ? pixel_in : h_prev_reg;

  // ---------------------------------------------------------------------
  // Line buffer
  //   Write: odd column of an even row stores the pair maximum.
  //   Read : issued on the even column of an odd row, so the registered
  //          read data is already stable when the odd column of the same
  //          pair arrives, however many idle cycles separate the two.
  //   Both ports use col/2, which is the same for the two columns of a pair.
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] lb_addr;
  logic              lb_wr_en;
  logic              lb_rd_en;
  logic [DATA_W-1:0] lb_rd_data;

  assign lb_addr  = ADDR_W'(col_reg >> 1);
  assign lb_wr_en = pixel_valid &&  col_odd && (state_reg == ROW_EVEN);
  assign lb_rd_en = pixel_valid && !col_odd && (state_reg == ROW_ODD);

  pool_line_buffer #(
    .DEPTH  (HALF_W),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_addr),
    .wr_data (hmax),
    .rd_en   (lb_rd_en),
    .rd_addr (lb_addr),
    .rd_data (lb_rd_data)
  );

  // ---------------------------------------------------------------------
  // Window completion: odd column of an odd row.
  // ---------------------------------------------------------------------
  logic              window_done;
  logic [DATA_W-1:0] pooled;

  assign window_done = pixel_valid && col_odd && (state_reg == ROW_ODD);
  assign pooled      = (lb_rd_data > hmax) ? lb_rd_data : hmax;

  // ---------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_reg    <= '0;
      row_reg    <= '0;
      state_reg  <= ROW_EVEN;
      h_prev_reg <= '0;
    end else begin
      col_reg   <= col_next;
      row_reg   <= row_next;
      state_reg <= state_next;
      if (pixel_valid && !col_odd) begin
        h_prev_reg <= pixel_in;
      end
    end
  end

  // Output register: valid and frame_done are single-cycle pulses, the
  // value itself is held between results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_out   <= '0;
      result_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      result_valid <= window_done;
      frame_done   <= window_done && row_last && col_last;
      if (window_done) begin
        result_out <= pooled;
      end
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
module tb_max_pool_2x2;
  import npu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: 2x2, instance 1: 4x4, instance 2: 32x32 (default).
  logic   t_valid, s_valid, b_valid;
  pixel_t t_pix,   s_pix,   b_pix;
  logic   t_rv,    s_rv,    b_rv;
  pixel_t t_res,   s_res,   b_res;
  logic   t_fd,    s_fd,    b_fd;

  max_pool_2x2 #(.IMG_W(2), .IMG_H(2)) dut_t (
    .clk(clk), .rst(rst), .pixel_valid(t_valid), .pixel_in(t_pix),
    .result_valid(t_rv), .result_out(t_res), .frame_done(t_fd));

  max_pool_2x2 #(.IMG_W(4), .IMG_H(4)) dut_s (
    .clk(clk), .rst(rst), .pixel_valid(s_valid), .pixel_in(s_pix),
    .result_valid(s_rv), .result_out(s_res), .frame_done(s_fd));

  max_pool_2x2 dut_b (
    .clk(clk), .rst(rst), .pixel_valid(b_valid), .pixel_in(b_pix),
    .result_valid(b_rv), .result_out(b_res), .frame_done(b_fd));

  typedef struct {
    int     inst;
    pixel_t val;
    int     cyc;
    bit     fd;
    bit     rv;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Output monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (t_rv || t_fd) got_q.push_back('{inst: 0, val: t_res, cyc: cyc, fd: t_fd, rv: t_rv});
    if (s_rv || s_fd) got_q.push_back('{inst: 1, val: s_res, cyc: cyc, fd: s_fd, rv: s_rv});
    if (b_rv || b_fd) got_q.push_back('{inst: 2, val: b_res, cyc: cyc, fd: b_fd, rv: b_rv});
  end

  function automatic pixel_t max2(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction

  task automatic drive(input int inst, input bit v, input pixel_t p);
    case (inst)
      0: begin t_valid = v; t_pix = p; end
      1: begin s_valid = v; s_pix = p; end
      default: begin b_valid = v; b_pix = p; end
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(0, 1'b0, '0);
      drive(1, 1'b0, '0);
      drive(2, 1'b0, '0);
    end
  endtask

  // Presents one pixel after 'gap' idle cycles; dcyc is the cycle counter
  // value at the moment the pixel is driven.
  task automatic send(input int inst, input pixel_t p, input int gap, output int dcyc);
    repeat (gap) begin
      @(negedge clk);
      drive(inst, 1'b0, '0);
    end
    @(negedge clk);
    drive(inst, 1'b1, p);
    dcyc = cyc;
  endtask

  // Reference model: sends a whole frame, then derives every pooled pixel
  // from the 2D image and its expected arrival cycle (one cycle after the
  // window's bottom-right pixel).
  task automatic send_frame(input int inst, input int w, input int h,
                            input pixel_t px[$], input int maxgap);
    int dc[$];
    int d;
    int gap;
    pixel_t m;
    for (int i = 0; i < w * h; i++) begin
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      send(inst, px[i], gap, d);
      dc.push_back(d);
    end
    for (int wr = 0; wr < h / 2; wr++) begin
      for (int wc = 0; wc < w / 2; wc++) begin
        m = max2(max2(px[(2*wr)*w + 2*wc],   px[(2*wr)*w + 2*wc + 1]),
                 max2(px[(2*wr+1)*w + 2*wc], px[(2*wr+1)*w + 2*wc + 1]));
        exp_q.push_back('{inst: inst, val: m, cyc: dc[(2*wr+1)*w + 2*wc + 1] + 1,
                          fd: (wr == h/2 - 1) && (wc == w/2 - 1), rv: 1'b1});
      end
    end
  endtask

  task automatic check_events(input string name);
    int n;
    idle(3);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s count: got %0d events, expected %0d", name, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_q[i].inst != exp_q[i].inst || got_q[i].val !== exp_q[i].val ||
          got_q[i].cyc != exp_q[i].cyc || got_q[i].fd != exp_q[i].fd ||
          got_q[i].rv != exp_q[i].rv) begin
        errors++;
        $display("FAIL %s event %0d: got inst=%0d val=%h cyc=%0d fd=%0b rv=%0b, expected inst=%0d val=%h cyc=%0d fd=%0b rv=1",
                 name, i, got_q[i].inst, got_q[i].val, got_q[i].cyc, got_q[i].fd, got_q[i].rv,
                 exp_q[i].inst, exp_q[i].val, exp_q[i].cyc, exp_q[i].fd);
      end else begin
        $display("event %s %0d: val=%h cyc=%0d fd=%0b", name, i, got_q[i].val, got_q[i].cyc, got_q[i].fd);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end else begin
      $display("check %s: %h", name, got);
    end
  endtask

  typedef struct {
    pixel_t a, b, c, d;
    pixel_t exp;
  } win_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    win_t   tbl[7];
    pixel_t ramp[$];
    pixel_t rev[$];
    pixel_t rnd[$];
    pixel_t ramp_exp[4];
    int     d0, d1, d2, d3, dx;

    tbl[0] = '{a: 22'h3FFFFF, b: 22'd0,      c: 22'd1,      d: 22'd2,      exp: 22'h3FFFFF};
    tbl[1] = '{a: 22'd9,      b: 22'd9,      c: 22'd9,      d: 22'd9,      exp: 22'd9};
    tbl[2] = '{a: 22'd0,      b: 22'd0,      c: 22'd0,      d: 22'd0,      exp: 22'd0};
    tbl[3] = '{a: 22'd1,      b: 22'd2,      c: 22'd3,      d: 22'd4,      exp: 22'd4};
    tbl[4] = '{a: 22'd0,      b: 22'h3FFFFF, c: 22'd5,      d: 22'd6,      exp: 22'h3FFFFF};
    tbl[5] = '{a: 22'd7,      b: 22'd8,      c: 22'h3FFFFE, d: 22'd1,      exp: 22'h3FFFFE};
    tbl[6] = '{a: 22'h200000, b: 22'h1FFFFF, c: 22'h0FFFFF, d: 22'h000001, exp: 22'h200000};

    ramp_exp[0] = 22'd5;  ramp_exp[1] = 22'd7;
    ramp_exp[2] = 22'd13; ramp_exp[3] = 22'd15;
    for (int i = 0; i < 16; i++) begin
      ramp.push_back(pixel_t'(i));
      rev.push_back(pixel_t'(15 - i));
    end

    // Reset state
    rst = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    drive(2, 1'b0, '0);
    repeat (3) @(negedge clk);
    check_val("reset_t", {8'd0, t_res, t_rv, t_fd}, 32'd0);
    check_val("reset_s", {8'd0, s_res, s_rv, s_fd}, 32'd0);
    check_val("reset_b", {8'd0, b_res, b_rv, b_fd}, 32'd0);
    rst = 1'b1;
    idle(2);

    // Table: one 2x2 window per frame on the 2x2 instance.
    for (int i = 0; i < 7; i++) begin
      send(0, tbl[i].a, 0, d0);
      send(0, tbl[i].b, 0, d1);
      send(0, tbl[i].c, 0, d2);
      send(0, tbl[i].d, 0, d3);
      idle(2);
      checks++;
      if (got_q.size() != 1) begin
        errors++;
        $display("FAIL table %0d count: got %0d results, expected 1", i, got_q.size());
      end else begin
        checks++;
        if (got_q[0].val !== tbl[i].exp || got_q[0].fd != 1'b1 || got_q[0].cyc != d3 + 1) begin
          errors++;
          $display("FAIL table %0d: got val=%h fd=%0b cyc=%0d, expected val=%h fd=1 cyc=%0d",
                   i, got_q[0].val, got_q[0].fd, got_q[0].cyc, tbl[i].exp, d3 + 1);
        end else begin
          $display("table %0d: val=%h", i, got_q[0].val);
        end
      end
      got_q.delete();
    end

    // 4x4 ramp, continuous; also compared against the literal 5,7,13,15.
    send_frame(1, 4, 4, ramp, 0);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i].val !== ramp_exp[i]) begin
        errors++;
        $display("FAIL ramp_const %0d: got %h, expected %h", i,
                 (got_q.size() > i) ? got_q[i].val : pixel_t'('1), ramp_exp[i]);
      end
    end
    check_events("ramp");

    // Same frame with random idle gaps.
    send_frame(1, 4, 4, ramp, 3);
    check_events("ramp_gaps");

    // Two back-to-back frames, no bubble between them.
    send_frame(1, 4, 4, ramp, 0);
    send_frame(1, 4, 4, rev, 0);
    check_events("back_to_back");

    // Reset after 6 pixels of a frame.
    for (int i = 0; i < 6; i++) send(1, ramp[i], 0, dx);
    idle(2);
    check_val("hold_before_reset", {8'd0, s_res, s_rv, s_fd}, {8'd0, 22'd5, 2'b00});
    #2 rst = 1'b0;
    #1 check_val("async_reset", {8'd0, s_res, s_rv, s_fd}, 32'd0);
    got_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    send_frame(1, 4, 4, ramp, 0);
    check_events("after_reset");

    // 32x32 random frame with occasional gaps.
    for (int i = 0; i < 32 * 32; i++) begin
      if (($urandom % 16) == 0) rnd.push_back(22'h3FFFFF - pixel_t'($urandom_range(0, 3)));
      else                      rnd.push_back(pixel_t'($urandom));
    end
    send_frame(2, 32, 32, rnd, 1);
    check_val("random_count", exp_q.size(), 32'd256);
    check_events("random32");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_pool_2x2.md
# max_pool_2x2

Streaming 2x2 max-pooling stage that consumes the post-activation pixel stream (`pixel_valid` / 22-bit pixel) leaving the ReLU stage. It takes one feature map of `IMG_W` x `IMG_H` pixels in raster order and emits one pooled pixel per non-overlapping 2x2 window, also in raster order. A half-width line buffer holds the even-row partial maxima. There is no backpressure: the block accepts a pixel on every cycle that `pixel_valid` is high.

## Interface
Parameters:
- `IMG_W`, 32: feature-map width in pixels; even, ≥ 2.
- `IMG_H`, 32: feature-map height in pixels; even, ≥ 2.
- `DATA_W`, 22: pixel width; taken from the shared package.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pixel_valid`  in  1  `pixel_in` is valid this cycle.
- `pixel_in`  in  `DATA_W`  post-ReLU pixel; compared as unsigned.
- `result_valid`  out  1  `result_out` holds a pooled pixel this cycle.
- `result_out`  out  `DATA_W`  max of one 2x2 window.
- `frame_done`  out  1  one-cycle pulse, coincident with the last pooled pixel of a frame.

## Operation
- Counters:
  - `col` runs 0..`IMG_W`-1 and `row` runs 0..`IMG_H`-1.
  - Both advance only on an accepted pixel (`pixel_valid` = 1).
  - `col` wraps to 0 and increments `row`.
  - `row` wraps to 0 after the last pixel of a frame.
- `h_prev` register: latches `pixel_in` on every accepted pixel with even `col`.
- Horizontal max: `hmax = max(h_prev, pixel_in)`, evaluated on accepted pixels with odd `col`.
- FSM, state derived from row parity:
  - ROW_EVEN: on odd `col`, write `hmax` to `line_buf[col>>1]`. No output.
  - ROW_ODD: on odd `col`, the pooled value is `max(line_buf[col>>1], hmax)`. It is registered into `result_out` with `result_valid` = 1.
  - Transitions: ROW_EVEN→ROW_ODD when `col` wraps on an even row. ROW_ODD→ROW_EVEN when `col` wraps on an odd row, including the frame wrap.
- Comparisons are unsigned at full `DATA_W`. There is no saturation or truncation; the output value is always one of the four inputs.
- Per frame, exactly (`IMG_W`/2)·(`IMG_H`/2) results are emitted.
- `frame_done` = 1 in the same cycle as the result for `row` = `IMG_H`-1, `col` = `IMG_W`-1.
- Back-to-back frames: the first pixel of the next frame may arrive in the cycle right after the last pixel of the previous one. No bubble is required.
- Gaps: any number of idle cycles between pixels, including mid-row, leave all state unchanged.

## Timing
- Latency: `result_valid` rises exactly 1 cycle after the accepted pixel that completes a window (the odd-row, odd-column pixel).
- `result_valid` and `frame_done` are high for exactly one cycle per event. `result_out` holds its last value while `result_valid` = 0.
- Throughput: 1 input pixel per cycle sustained. Output peak is 1 result per 2 cycles.
- Line buffer: written during even rows and read during odd rows. No same-address read/write ever occurs in one cycle, so read-during-write behaviour is don't-care. The read is combinational or same-cycle registered as long as the 1-cycle latency is met.
- Reset (`rst` = 0, asynchronous, at any time including mid-frame):
  - `result_out` = 0, `result_valid` = 0, `frame_done` = 0.
  - `col` = 0, `row` = 0, `h_prev` = 0, FSM = ROW_EVEN.
  - `line_buf` contents are not reset. They are always rewritten before being read.
  - After release, the next accepted pixel is treated as (0,0) of a new frame.

## Structure
- Shared package `npu_pkg` holds `DATA_W` = 22 and `typedef logic [DATA_W-1:0] pixel_t`. Both the activation stage and this block use them.
- Sub-module `pool_line_buffer`: simple dual-port storage, depth `IMG_W`/2, width `DATA_W`, with one write port and one read port. It has no reset.
- The top level contains the counters, the row-parity FSM, the comparators and the output register.

## Test plan
- 4x4 frame (`IMG_W` = `IMG_H` = 4), pixels 0..15 in raster order, continuous valid → results 5, 7, 13, 15. Each appears 1 cycle after pixels 5, 7, 13, 15 respectively. `frame_done` coincides with 15.
- Same frame with random 0–3 idle cycles between pixels → identical results and order. Result count is 4. No `result_valid` during even rows.
- Window {22'h3FFFFF, 0, 1, 2} → result 22'h3FFFFF, which checks the unsigned full-width compare. A window with all values equal to 9 → 9.
- Two back-to-back 4x4 frames with no gap, the second being 15..0 → 5,7,13,15 then 15,13,7,5. `frame_done` pulses twice.
- Assert `rst` low for 1 cycle after 6 pixels of a frame → all outputs 0 immediately. A fresh 0..15 frame afterward yields 5, 7, 13, 15 with no stale line-buffer data.
- Default 32x32 frame of random data checked against a reference model → 256 results, all matching, and exactly one `frame_done`.
